// File: rtl/mcycle_pkg.sv
// Shared types and constants for the multi-cycle MUL/DIV unit and its decoder.
// The op encoding is part of the decoder contract and must not change.
package mcycle_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mcycle_state_t;

  localparam logic MCYCLE_OP_MUL = 1'b0;
  localparam logic MCYCLE_OP_DIV = 1'b1;

  // Iteration counter width; WIDTH-1 must be representable.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mcycle_if.sv
// Decoder <-> multi-cycle unit start/done handshake bundle.
// Start is a level request held until Done; Busy/Done are registered Moore outputs.
interface mcycle_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, MCycleOp, Operand1, Operand2,
    input  Result1, Result2, Busy, Done
  );

  modport slave (
    input  Start, MCycleOp, Operand1, Operand2,
    output Result1, Result2, Busy, Done
  );
endinterface

// File: rtl/mcycle_divstep.sv
// One combinational restoring-division step: trial-subtract divisor from the shifted remainder.
// Zero latency; no handshake (pure datapath, used only when MCYCLE_DIV_EN is defined).
module mcycle_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   part_rem,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);
  logic [WIDTH:0] diff;

  // The kept remainder is always below the divisor, so WIDTH bits suffice.
  assign diff     = part_rem - {1'b0, divisor};
  assign q_bit    = ~diff[WIDTH];
  assign next_rem = q_bit ? diff[WIDTH-1:0] : part_rem[WIDTH-1:0];
endmodule

// File: rtl/mcycle.sv
// Multi-cycle unsigned MUL (shift-add) / DIV (restoring, only with MCYCLE_DIV_EN), one bit per cycle.
// Latency WIDTH+1 from the Start edge; Start ignored outside IDLE, single-cycle Done pulse.
module mcycle
  import mcycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic     CLK,
  input logic     RESET,
  mcycle_if.slave mc
);
  localparam int             CW   = cnt_width(WIDTH);
  localparam int             AW   = 2 * WIDTH;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  mcycle_state_t    state;
  logic [CW-1:0]    cnt;
  logic             op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [AW-1:0]    acc;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] res1_q;
  logic [WIDTH-1:0] res2_q;

  // MUL: a_q is the fixed multiplicand, b_q shifts the multiplier out LSB-first.
  logic [WIDTH:0]   upper_sum;
  logic [AW-1:0]    acc_nxt;

  assign upper_sum = {1'b0, acc[AW-1:WIDTH]} + {1'b0, {WIDTH{b_q[0]}} & a_q};
  assign acc_nxt   = AW'({upper_sum, acc[WIDTH-1:0]} >> 1);

  logic [WIDTH-1:0] div_r1;
  logic [WIDTH-1:0] div_r2;

`ifdef MCYCLE_DIV_EN
  // DIV: a_q shifts the dividend out MSB-first, b_q holds the divisor.
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] quo_nxt;
  logic             q_bit;

  mcycle_divstep #(.WIDTH(WIDTH)) u_divstep (
    .part_rem ({rem_q, a_q[WIDTH-1]}),
    .divisor  (b_q),
    .next_rem (rem_nxt),
    .q_bit    (q_bit)
  );

  assign quo_nxt = {quo_q[WIDTH-2:0], q_bit};
  assign div_r1  = quo_nxt;
  assign div_r2  = rem_nxt;
`else
  assign div_r1  = '0;
  assign div_r2  = '0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= MCYCLE_OP_MUL;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res1_q <= '0;
      res2_q <= '0;
`ifdef MCYCLE_DIV_EN
      rem_q  <= '0;
      quo_q  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (mc.Start) begin
            state  <= BUSY;
            busy_q <= 1'b1;
            op_q   <= mc.MCycleOp;
            a_q    <= mc.Operand1;
            b_q    <= mc.Operand2;
            acc    <= '0;
            cnt    <= '0;
`ifdef MCYCLE_DIV_EN
            rem_q  <= '0;
            quo_q  <= '0;
`endif
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (op_q == MCYCLE_OP_MUL) begin
            acc <= acc_nxt;
            b_q <= b_q >> 1;
          end
`ifdef MCYCLE_DIV_EN
          else begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            a_q   <= a_q << 1;
          end
`endif
          // Results capture the final iteration's next-state values directly.
          if (cnt == LAST) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            res1_q <= (op_q == MCYCLE_OP_MUL) ? acc_nxt[WIDTH-1:0] : div_r1;
            res2_q <= (op_q == MCYCLE_OP_MUL) ? acc_nxt[AW-1:WIDTH] : div_r2;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign mc.Busy    = busy_q;
  assign mc.Done    = done_q;
  assign mc.Result1 = res1_q;
  assign mc.Result2 = res2_q;

endmodule

// File: tb/tb_mcycle.sv
// Directed scoreboard bench for mcycle: latency, Busy length, results, hold, reset abort, back-to-back.
// Expected DIV results follow MCYCLE_DIV_EN (zeros when the divider is not built).
module tb_mcycle;
  import mcycle_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mcycle_if #(.WIDTH(W)) mc_if ();

  mcycle #(.WIDTH(W)) dut (
    .CLK   (clk),
    .RESET (rst),
    .mc    (mc_if)
  );

  typedef struct packed {
    logic [W-1:0] r1;
    logic [W-1:0] r2;
  } exp_t;

  exp_t         sb[$];
  int           passed = 0;
  int           total  = 0;
  logic [W-1:0] last_r1 = '0;
  logic [W-1:0] last_r2 = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    exp_t        e;
    e = '0;
    if (op == MCYCLE_OP_MUL) begin
      p    = 64'(a) * 64'(b);
      e.r1 = p[31:0];
      e.r2 = p[63:32];
    end else begin
`ifdef MCYCLE_DIV_EN
      if (b == '0) begin
        e.r1 = '1;
        e.r2 = a;
      end else begin
        e.r1 = a / b;
        e.r2 = a % b;
      end
`endif
    end
    return e;
  endfunction

  task automatic drive_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    mc_if.Start    = 1'b1;
    mc_if.MCycleOp = op;
    mc_if.Operand1 = a;
    mc_if.Operand2 = b;
    sb.push_back(model(op, a, b));
  endtask

  // Called right after the accepting edge; returns at the negedge of the Done cycle.
  task automatic wait_done(input string tag);
    int   busy_n;
    bit   seen;
    exp_t e;
    busy_n = 0;
    seen   = 1'b0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clk);
      if (mc_if.Busy === 1'b1) busy_n++;
      if (k == 2) begin
        check($sformatf("%s_hold_r1", tag), 64'(mc_if.Result1), 64'(last_r1));
        check($sformatf("%s_hold_r2", tag), 64'(mc_if.Result2), 64'(last_r2));
      end
      if (k >= 3 && k <= 30) begin
        mc_if.Operand1 = $urandom;
        mc_if.Operand2 = $urandom;
        mc_if.MCycleOp = 1'($urandom_range(0, 1));
      end
      if (mc_if.Done === 1'b1) begin
        seen = 1'b1;
        e    = sb.pop_front();
        check($sformatf("%s_latency", tag), 64'(k), 64'(W + 1));
        check($sformatf("%s_busy_cycles", tag), 64'(busy_n), 64'(W));
        check($sformatf("%s_result1", tag), 64'(mc_if.Result1), 64'(e.r1));
        check($sformatf("%s_result2", tag), 64'(mc_if.Result2), 64'(e.r2));
        last_r1 = e.r1;
        last_r2 = e.r2;
      end
    end
    if (!seen) check($sformatf("%s_done_timeout", tag), 64'(0), 64'(1));
  endtask

  task automatic single_op(input string tag, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    drive_op(op, a, b);
    @(posedge clk);
    wait_done(tag);
    mc_if.Start = 1'b0;
  endtask

  initial begin
    int done_n;

    rst            = 1'b1;
    mc_if.Start    = 1'b0;
    mc_if.MCycleOp = MCYCLE_OP_MUL;
    mc_if.Operand1 = '0;
    mc_if.Operand2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 64'(mc_if.Busy), 64'(0));
    check("reset_done", 64'(mc_if.Done), 64'(0));
    check("reset_r1", 64'(mc_if.Result1), 64'(0));
    check("reset_r2", 64'(mc_if.Result2), 64'(0));
    rst = 1'b0;

    single_op("mul_7x6", MCYCLE_OP_MUL, 32'd7, 32'd6);
    single_op("mul_max", MCYCLE_OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    single_op("div_100_7", MCYCLE_OP_DIV, 32'd100, 32'd7);
    single_op("div_msb_1", MCYCLE_OP_DIV, 32'h8000_0000, 32'd1);
    single_op("div_5_0", MCYCLE_OP_DIV, 32'd5, 32'd0);
    single_op("mul_big", MCYCLE_OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0);

    // Reset in the middle of a MUL: no Done, results cleared.
    @(negedge clk);
    mc_if.Start    = 1'b1;
    mc_if.MCycleOp = MCYCLE_OP_MUL;
    mc_if.Operand1 = 32'd123;
    mc_if.Operand2 = 32'd456;
    @(posedge clk);
    repeat (10) @(negedge clk);
    rst         = 1'b1;
    mc_if.Start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(mc_if.Busy), 64'(0));
    check("abort_done", 64'(mc_if.Done), 64'(0));
    check("abort_r1", 64'(mc_if.Result1), 64'(0));
    check("abort_r2", 64'(mc_if.Result2), 64'(0));
    done_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mc_if.Done !== 1'b0) done_n++;
    end
    check("abort_no_done", 64'(done_n), 64'(0));
    last_r1 = '0;
    last_r2 = '0;

    // Start held high across two ops; second operands applied in the Done cycle.
    @(negedge clk);
    drive_op(MCYCLE_OP_MUL, 32'd3, 32'd4);
    @(posedge clk);
    wait_done("b2b_mul");
    drive_op(MCYCLE_OP_DIV, 32'd9, 32'd2);
    @(negedge clk);
    check("b2b_idle_busy", 64'(mc_if.Busy), 64'(0));
    check("b2b_idle_done", 64'(mc_if.Done), 64'(0));
    @(posedge clk);
    wait_done("b2b_div");
    mc_if.Start = 1'b0;

    @(negedge clk);
    check("post_idle_busy", 64'(mc_if.Busy), 64'(0));
    check("post_hold_r1", 64'(mc_if.Result1), 64'(last_r1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mcycle.md
# mcycle

Multi-cycle arithmetic unit answering the instruction decoder's multi-cycle start/done handshake. It accepts an unsigned multiply (MUL) or unsigned divide (DIV) request and iterates one bit per cycle. It then presents a one-cycle `Done` pulse, which the decoder forwards as the register-file write enable for the result. It sits beside the ALU in the execute stage; the pipeline stalls while `Start` is high and `Done` is low.

## Interface
- `WIDTH`, 32, operand/result width; iteration count equals `WIDTH`
- `CLK` in 1: single clock, all state updates on the rising edge
- `RESET` in 1: synchronous, active-high
- `Start` in 1: level request from the decoder; held high until `Done` is seen
- `MCycleOp` in 1: 0 = MUL, 1 = DIV; sampled with `Start`
- `Operand1` in WIDTH: multiplicand / dividend; sampled with `Start`
- `Operand2` in WIDTH: multiplier / divisor; sampled with `Start`
- `Result1` out WIDTH: MUL gives product[WIDTH-1:0]; DIV gives quotient
- `Result2` out WIDTH: MUL gives product[2*WIDTH-1:WIDTH]; DIV gives remainder
- `Busy` out 1: iteration in progress
- `Done` out 1: single-cycle pulse; results valid

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE to BUSY on `Start`=1 at a clock edge. That edge latches the operands and `MCycleOp`, clears the accumulator, and clears the counter.
  - BUSY to DONE when the counter reaches `WIDTH`-1 on an edge, i.e. after exactly `WIDTH` iterations.
  - DONE to IDLE unconditionally.
- `Start` is ignored outside IDLE. Changes to the operand or op inputs during BUSY or DONE have no effect.
- MUL uses shift-add, LSB-first, over a 2·WIDTH accumulator. When multiplier bit i is 1, add the multiplicand into the upper half, then shift the whole accumulator right by 1, keeping the adder carry.
- DIV uses restoring division, MSB-first, over a WIDTH+1-bit partial remainder:
  - Shift the next dividend bit into the partial remainder.
  - Trial-subtract the divisor.
  - If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the quotient bit to 0.
- Divide by zero is not trapped. The natural algorithm result is required: quotient = all ones, remainder = dividend.
- `Result1` and `Result2` are registered. They load on the BUSY-to-DONE edge and hold until the next accepted `Start`; they are not cleared by that `Start`.
- `Busy` = (state == BUSY). `Done` = (state == DONE). Both are Moore outputs.
- Reset values: state IDLE; `Busy` 0; `Done` 0; `Result1` 0; `Result2` 0; counter and accumulators 0.

## Timing
- `Start` is sampled at edge t0. `Busy` is high for cycles t0+1 through t0+WIDTH. `Done` is high for cycle t0+WIDTH+1 only. Latency is WIDTH+1 cycles (33 for the default).
- `Start` held high through `Done`: the state is IDLE in cycle t0+WIDTH+2. If `Start` is still high there, with the next instruction's operands, a new operation is accepted at that edge. Back-to-back operations have a throughput of one per WIDTH+2 cycles.
- `RESET` mid-operation: state returns to IDLE on the next edge, results are cleared, and no `Done` is produced. `RESET` has priority over `Start` on the same edge.
- No combinational path from any input to `Busy` or `Done`.

## Configuration
- `MCYCLE_DIV_EN` defined: the divider datapath is compiled in and DIV behaves as specified above.
- `MCYCLE_DIV_EN` undefined: no divider hardware. A DIV request still follows IDLE to BUSY to DONE with identical latency, and returns `Result1` = 0 and `Result2` = 0. MUL is unaffected.

## Structure
- Shared package `mcycle_pkg`:
  - FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
  - op constants `MCYCLE_OP_MUL`=1'b0 and `MCYCLE_OP_DIV`=1'b1, shared with the decoder
- Sub-module `mcycle_divstep`: one combinational restoring-division step (partial remainder and divisor in; next remainder and quotient bit out). It is instantiated only under `MCYCLE_DIV_EN`. The FSM, counter, and multiply step stay in `mcycle`.

## Test plan
- MUL, 7 × 6: `Done` at t0+33; `Result1`=42, `Result2`=0; `Busy` high for exactly 32 cycles.
- MUL, 0xFFFFFFFF × 0xFFFFFFFF: `Result1`=0x00000001, `Result2`=0xFFFFFFFE (checks carry retention).
- DIV, 100 / 7: `Result1`=14, `Result2`=2. Also 0x80000000 / 1: `Result1`=0x80000000, `Result2`=0.
- DIV, 5 / 0: `Result1`=0xFFFFFFFF, `Result2`=5. With the macro undefined, the same request gives 0 / 0 at t0+33.
- `RESET` pulsed at cycle t0+10 of a MUL: `Busy`=0 the next cycle, `Done` never asserts, results read 0.
- `Start` held high across two ops (3×4, then 9/2, operands switched in the `Done` cycle): `Done` pulses at t0+33 and t0+67 with 12, then quotient 4 and remainder 1; operand changes during BUSY have no effect.
